// File: rtl/gl_pkg.sv
// Shared definitions for the graphics pipeline back end: default screen
// geometry, pixel format and the pixel-writer state encoding.
package gl_pkg;

  localparam int DEF_COLOR_W  = 24;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Smallest address width that covers every pixel of a w x h framebuffer.
  function automatic int fb_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int DEF_ADDR_W = fb_addr_w(DEF_SCREEN_W, DEF_SCREEN_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } wr_state_e;

endpackage

// File: rtl/gl_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port. Push and pop
// may happen together at any fill level; callers must not push when full
// or pop when empty.
module gl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = store_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/gl_pixel_writer.sv
// Pixel writer: clips rasterizer fragments to the screen, queues in-range
// fragments with their linear framebuffer address, and drains them to the
// memory port over req/ack. Also fills the whole screen on a clear request.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no request outstanding; chooses clear or next fragment
//   ST_WRITE | fragment write presented on mem_*, waiting for mem_ack
//   ST_CLEAR | fill write at clear address presented, waiting for mem_ack
module gl_pixel_writer
  import gl_pkg::*;
#(
  parameter int WIDTH      = DEF_SCREEN_W,
  parameter int HEIGHT     = DEF_SCREEN_H,
  parameter int ADDR_W     = fb_addr_w(WIDTH, HEIGHT),
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [31:0]        pix_x,
  input  logic [31:0]        pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               pix_ready,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic [31:0]        pix_written,
  output logic [31:0]        pix_clipped
);

  localparam int ENTRY_W = ADDR_W + COLOR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
  localparam logic [31:0]       WIDTH_32  = 32'(WIDTH);
  localparam logic [31:0]       HEIGHT_32 = 32'(HEIGHT);

  wr_state_e state_q, state_d;

  logic               clr_pending_q, clr_pending_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0] mem_data_q, mem_data_d;
  logic [31:0]        written_q, written_d;
  logic [31:0]        clipped_q, clipped_d;
  logic               done_q, done_d;
  // Holds pix_ready low while in reset and for the first cycle after it.
  logic               run_q, run_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

  logic               busy;
  logic               accept;
  logic               out_of_range;
  logic [ADDR_W-1:0]  lin_addr;
  logic               start_clear;
  logic               clear_last;

  // Clip test and linear address. Only the low ADDR_W bits of y*WIDTH+x
  // matter, so the product is formed directly at that width.
  always_comb begin
    out_of_range = pix_x[31] || pix_y[31] ||
                   (pix_x >= WIDTH_32) || (pix_y >= HEIGHT_32);
    lin_addr     = pix_y[ADDR_W-1:0] * WIDTH_A + pix_x[ADDR_W-1:0];
    accept       = pix_valid && pix_ready;
    fifo_push    = accept && !out_of_range;
    fifo_wdata   = {lin_addr, pix_color};
  end

  gl_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_frag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state. A pending clear waits for the queue to drain, and
  // blocks back-to-back pops so queued fragments land before the fill.
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    start_clear = 1'b0;
    clear_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_pending_q && fifo_empty) begin
          state_d     = ST_CLEAR;
          start_clear = 1'b1;
        end else if (!fifo_empty) begin
          state_d  = ST_WRITE;
          fifo_pop = 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (!fifo_empty && !clr_pending_q) fifo_pop = 1'b1;
          else                               state_d  = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (mem_ack && (mem_addr_q == LAST_ADDR)) begin
          state_d    = ST_IDLE;
          clear_last = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, all decoded from registered state.
  always_comb begin
    mem_req    = (state_q != ST_IDLE);
    busy       = clr_pending_q || (state_q == ST_CLEAR);
    clear_busy = busy;
    pix_ready  = run_q && !fifo_full && !busy;
  end

  // Datapath next values: write registers, clear bookkeeping, counters.
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    clr_pending_d = clr_pending_q;
    clr_color_d   = clr_color_q;
    written_d     = written_q;
    clipped_d     = clipped_q;
    done_d        = clear_last;
    run_d         = 1'b1;

    if (fifo_pop) begin
      {mem_addr_d, mem_data_d} = fifo_rdata;
    end else if (start_clear) begin
      mem_addr_d = '0;
      mem_data_d = clr_color_q;
    end else if ((state_q == ST_CLEAR) && mem_ack && !clear_last) begin
      mem_addr_d = mem_addr_q + ADDR_W'(1);
    end

    if (clear_start && !busy) begin
      clr_pending_d = 1'b1;
      clr_color_d   = clear_color;
    end else if (start_clear) begin
      clr_pending_d = 1'b0;
    end

    if ((state_q == ST_WRITE) && mem_ack) written_d = written_q + 32'd1;
    if (accept && out_of_range)           clipped_d = clipped_q + 32'd1;
  end

  // Datapath registers; reset abandons any write or clear in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      clr_pending_q <= 1'b0;
      clr_color_q   <= '0;
      written_q     <= '0;
      clipped_q     <= '0;
      done_q        <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      clr_pending_q <= clr_pending_d;
      clr_color_q   <= clr_color_d;
      written_q     <= written_d;
      clipped_q     <= clipped_d;
      done_q        <= done_d;
      run_q         <= run_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign clear_done  = done_q;
  assign pix_written = written_q;
  assign pix_clipped = clipped_q;

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_pop && fifo_empty));
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_gl_pixel_writer.sv
module tb_gl_pixel_writer;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 4;
  localparam int CW   = 24;
  localparam int FD   = 8;
  localparam int NPIX = W * H;

  logic          clk;
  logic          rst_n;
  logic          pix_valid;
  logic [31:0]   pix_x, pix_y;
  logic [CW-1:0] pix_color;
  logic          pix_ready;
  logic          clear_start;
  logic [CW-1:0] clear_color;
  logic          clear_busy, clear_done;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data;
  logic          mem_ack;
  logic [31:0]   pix_written, pix_clipped;

  gl_pixel_writer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .COLOR_W(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_ready(pix_ready),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .pix_written(pix_written), .pix_clipped(pix_clipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    bit            is_clr;
  } wr_t;

  wr_t           exp_q[$];
  logic [CW-1:0] ref_img [NPIX];
  logic [CW-1:0] fb_mem  [NPIX];
  int passed = 0, total = 0;
  int exp_written = 0, exp_clipped = 0;
  int hs_cnt = 0, done_cnt = 0;
  int ack_mode = 1;  // 0: hold low, 1: tied high, 2: random 0-3 cycle delay

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pixel either counts as clipped or becomes one write.
  task automatic model_accept(input int x, input int y, input logic [CW-1:0] c);
    int a;
    if (x < 0 || y < 0 || x >= W || y >= H) begin
      exp_clipped++;
    end else begin
      a = y * W + x;
      exp_q.push_back('{addr: AW'(a), data: c, is_clr: 1'b0});
      ref_img[a] = c;
    end
  endtask

  task automatic model_clear(input logic [CW-1:0] c);
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back('{addr: AW'(i), data: c, is_clr: 1'b1});
      ref_img[i] = c;
    end
  endtask

  // Memory side: drives mem_ack and scores every completed handshake.
  int            wait_cnt = -1;
  logic          held_v = 1'b0;
  logic [AW-1:0] h_addr;
  logic [CW-1:0] h_data;
  wr_t           mon_e;
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack  = 1'b0;
        held_v   = 1'b0;
        wait_cnt = -1;
      end else begin
        if (ack_mode == 0) mem_ack = 1'b0;
        else if (ack_mode == 1) mem_ack = 1'b1;
        else if (!mem_req) mem_ack = 1'b0;
        else begin
          if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
          if (wait_cnt == 0) begin
            mem_ack  = 1'b1;
            wait_cnt = -1;
          end else begin
            mem_ack = 1'b0;
            wait_cnt--;
          end
        end
        if (mem_req && held_v) chk("addr_stable", {mem_addr, mem_data}, {h_addr, h_data});
        if (mem_req && mem_ack) begin
          hs_cnt++;
          held_v = 1'b0;
          fb_mem[mem_addr] = mem_data;
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
            chk("wr_data", 64'(mem_data), 64'(mon_e.data));
            if (!mon_e.is_clr) exp_written++;
          end
        end else if (mem_req) begin
          held_v = 1'b1;
          h_addr = mem_addr;
          h_data = mem_data;
        end else begin
          held_v = 1'b0;
        end
        if (clear_done) done_cnt++;
      end
    end
  end

  task automatic drive_pixel(input int x, input int y, input logic [CW-1:0] c);
    bit got = 1'b0;
    pix_valid = 1'b1;
    pix_x = x;
    pix_y = y;
    pix_color = c;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (pix_ready) begin
        model_accept(x, y, c);
        got = 1'b1;
      end
      tick();
    end
    pix_valid = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL pixel_accept_timeout: x=%0d y=%0d never accepted", x, y);
    end
  endtask

  task automatic send_clear(input logic [CW-1:0] c, output bit acc);
    clear_start = 1'b1;
    clear_color = c;
    @(negedge clk);
    acc = !clear_busy;
    if (acc) model_clear(c);
    tick();
    clear_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mem_req && !clear_busy) ok = 1'b1;
    end
    tick();
    if (!ok) begin
      total++;
      $display("FAIL %s_drain_timeout: %0d writes still expected", name, exp_q.size());
    end
  endtask

  task automatic cmp_image(input string name);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s_img[%0d]", name, i), 64'(fb_mem[i]), 64'(ref_img[i]));
  endtask

  function automatic int rand_coord();
    int r = int'($urandom_range(0, 9));
    case (r)
      0:       return -1 - int'($urandom_range(0, 1000));
      1:       return W + int'($urandom_range(0, 1000));
      2:       return 32'h7fff_ffff;
      default: return int'($urandom_range(0, W - 1));
    endcase
  endfunction

  bit   acc_b;
  int   acc_n, hs0, d0, base;
  int   cx, cy;
  bit   bad_ready, found, saw_req;
  logic [CW-1:0] cc;

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ref_img[i] = '0;
      fb_mem[i]  = '0;
    end
    rst_n = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clear_start = 1'b0; clear_color = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", 64'(pix_ready), 0);
    chk("rst_clear_busy", 64'(clear_busy), 0);
    chk("rst_clear_done", 64'(clear_done), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_data", 64'(mem_data), 0);
    chk("rst_written", 64'(pix_written), 0);
    chk("rst_clipped", 64'(pix_clipped), 0);
    rst_n = 1'b1;
    tick(); tick();

    // Single pixel: request appears one edge after the accepting edge.
    ack_mode = 1;
    pix_valid = 1'b1; pix_x = 1; pix_y = 2; pix_color = 24'hFF0000;
    @(negedge clk);
    chk("t1_ready", 64'(pix_ready), 1);
    if (pix_ready) model_accept(1, 2, 24'hFF0000);
    tick();
    pix_valid = 1'b0;
    chk("t1_req_not_yet", 64'(mem_req), 0);
    tick();
    chk("t1_req", 64'(mem_req), 1);
    chk("t1_addr", 64'(mem_addr), 9);
    chk("t1_data", 64'(mem_data), 64'h00FF0000);
    wait_idle("t1");
    chk("t1_written", 64'(pix_written), 1);

    // Clipping at each edge of the screen.
    drive_pixel(-1, 0, 24'h111111);
    drive_pixel(4, 0, 24'h222222);
    drive_pixel(0, 4, 24'h333333);
    drive_pixel(3, 3, 24'h444444);
    wait_idle("t2");
    chk("t2_clipped", 64'(pix_clipped), 64'(exp_clipped));
    chk("t2_written", 64'(pix_written), 64'(exp_written));
    chk("t2_fb15", 64'(fb_mem[15]), 64'h00444444);

    // Backpressure: one entry in the write register plus a full queue.
    ack_mode = 0;
    acc_n = 0;
    cx = int'($urandom_range(0, W - 1)); cy = int'($urandom_range(0, H - 1));
    cc = CW'($urandom);
    pix_valid = 1'b1; pix_x = cx; pix_y = cy; pix_color = cc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc_b = pix_ready;
      if (acc_b) begin
        model_accept(cx, cy, cc);
        acc_n++;
      end
      tick();
      if (acc_b) begin
        cx = int'($urandom_range(0, W - 1)); cy = int'($urandom_range(0, H - 1));
        cc = CW'($urandom);
        pix_x = cx; pix_y = cy; pix_color = cc;
      end
    end
    pix_valid = 1'b0;
    chk("t3_accepted", 64'(acc_n), 64'(FD + 1));
    chk("t3_ready_low", 64'(pix_ready), 0);
    hs0 = hs_cnt;
    ack_mode = 1;
    repeat (FD + 1) @(negedge clk);
    #1;
    chk("t3_back_to_back", 64'(hs_cnt - hs0), 64'(FD + 1));
    wait_idle("t3");

    // Clear behind two queued fragments; a second clear and a pixel
    // offered while busy must both be refused.
    ack_mode = 0;
    drive_pixel(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 24'hABCDEF);
    drive_pixel(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 24'h13579B);
    d0 = done_cnt;
    send_clear(24'h00FF00, acc_b);
    chk("t4_clear_accepted", 64'(acc_b), 1);
    chk("t4_busy_next", 64'(clear_busy), 1);
    ack_mode = 1;
    pix_valid = 1'b1; pix_x = 2; pix_y = 1; pix_color = 24'h0000AA;
    clear_start = 1'b1; clear_color = 24'h123456;
    @(negedge clk);
    if (!clear_busy) model_clear(24'h123456);
    tick();
    clear_start = 1'b0;
    bad_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!clear_busy) found = 1'b1;
      else begin
        if (pix_ready) bad_ready = 1'b1;
        tick();
      end
    end
    chk("t4_busy_ended", 64'(found), 1);
    chk("t4_busy_until_last", 64'(exp_q.size()), 0);
    if (pix_ready) model_accept(2, 1, 24'h0000AA);
    tick();
    pix_valid = 1'b0;
    chk("t4_ready_low_while_busy", 64'(bad_ready), 0);
    wait_idle("t4");
    chk("t4_done_once", 64'(done_cnt - d0), 1);
    cmp_image("t4");

    // Random traffic with random ack latency.
    ack_mode = 2;
    base = exp_written + exp_clipped;
    for (int n = 0; n < 200; n++) begin
      drive_pixel(rand_coord(), rand_coord(), CW'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle("t5");
    cmp_image("t5");
    chk("t5_written", 64'(pix_written), 64'(exp_written));
    chk("t5_clipped", 64'(pix_clipped), 64'(exp_clipped));
    chk("t5_sum", 64'(pix_written + pix_clipped), 64'(base + 200));

    // Reset in the middle of a clear.
    ack_mode = 1;
    send_clear(24'h0000FF, acc_b);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      #2;
      if (mem_req && mem_addr == AW'(7)) begin
        rst_n = 1'b0;
        found = 1'b1;
      end
    end
    chk("t6_reached_addr7", 64'(found), 1);
    #1;
    chk("t6_req_dropped", 64'(mem_req), 0);
    chk("t6_busy_dropped", 64'(clear_busy), 0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    exp_written = 0;
    exp_clipped = 0;
    tick(); tick();
    chk("t6_written_zero", 64'(pix_written), 0);
    chk("t6_clipped_zero", 64'(pix_clipped), 0);
    chk("t6_ready", 64'(pix_ready), 1);
    saw_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req || clear_busy) saw_req = 1'b1;
      tick();
    end
    chk("t6_stays_idle", 64'(saw_req), 0);
    drive_pixel(0, 0, 24'h5A5A5A);
    wait_idle("t6");
    chk("t6_post_written", 64'(pix_written), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
